chi_txreq_link_ctrl: RTL

CHI link-layer transmitter for the TX REQ channel. Sits directly upstream of chi_monitor and drives TXREQFLITPEND/TXREQFLITV/TXREQFLIT plus the link-activation handshake. It buffers protocol request flits from the RN request generator and spends L-credits received on TXREQLCRDV. On link deactivation it returns any unused credits as ReqLCrdReturn link flits.

---
 rtl/chi_link_pkg.sv | 26 ++
 rtl/chi_flit_fifo.sv | 55 +++++
 rtl/chi_txreq_link_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/chi_link_pkg.sv
// Shared CHI link-layer definitions: link FSM states, REQ flit field positions
// and credit limits used by the TX channel controllers.
package chi_link_pkg;

  typedef enum logic [1:0] {
    LINK_STOP       = 2'd0,
    LINK_ACTIVATE   = 2'd1,
    LINK_RUN        = 2'd2,
    LINK_DEACTIVATE = 2'd3
  } link_state_e;

  localparam int REQ_QOS_LSB    = 0;
  localparam int REQ_QOS_MSB    = 3;
  localparam int REQ_TGTID_LSB  = 4;
  localparam int REQ_TGTID_MSB  = 14;
  localparam int REQ_SRCID_LSB  = 15;
  localparam int REQ_SRCID_MSB  = 25;
  localparam int REQ_TXNID_LSB  = 26;
  localparam int REQ_TXNID_MSB  = 37;
  localparam int REQ_OPCODE_LSB = 62;
  localparam int REQ_OPCODE_MSB = 68;

  localparam logic [6:0] REQ_OPC_LCRDRETURN = 7'd0;
  localparam int         CHI_MAX_CRD        = 15;

endpackage

// File: rtl/chi_flit_fifo.sv
// Synchronous flit FIFO with full/empty flags and a registered read port:
// pop_data holds the popped entry from the cycle after pop.
module chi_flit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 154
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] pop_data_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = pop_data_reg;

  // Storage has no reset so it maps onto RAM; only pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      pop_data_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        pop_data_reg <= mem[rd_ptr_reg];
      end
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/chi_txreq_link_ctrl.sv
// CHI TX REQ link-layer transmitter: link activation FSM, L-credit accounting,
// request buffering and credit return on deactivation. Optional perf counters
// are built when CHI_TXREQ_PERF_EN is defined.
module chi_txreq_link_ctrl
  import chi_link_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_CRD = CHI_MAX_CRD,
  parameter int FLIT_W  = 154
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              link_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              TXLINKACTIVEREQ,
  input  logic              TXLINKACTIVEACK,
  input  logic              TXREQLCRDV,
  output logic              TXREQFLITPEND,
  output logic              TXREQFLITV,
  output logic [FLIT_W-1:0] TXREQFLIT,
  output logic [3:0]        crd_cnt,
  output logic [1:0]        link_state,
  output logic              crd_ovf,
  output logic [31:0]       perf_sent,
  output logic [31:0]       perf_stall
);

  link_state_e       state_reg, state_next;
  logic [3:0]        crd_cnt_reg;
  logic              crd_ovf_reg;
  logic              pend_reg;
  logic              flitv_reg;
  logic              proto_reg;
  logic              send;
  logic              pop;
  logic              grant;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FLIT_W-1:0] fifo_dout;
  logic [FLIT_W-1:0] lcrd_flit;

  chi_flit_fifo #(.DEPTH(DEPTH), .WIDTH(FLIT_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_flit),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign grant    = TXREQLCRDV && (state_reg != LINK_STOP);

  always_comb begin
    send = 1'b0;
    pop  = 1'b0;
    if (state_reg == LINK_RUN) begin
      send = !fifo_empty && (crd_cnt_reg != '0);
      pop  = send;
    end else if (state_reg == LINK_DEACTIVATE) begin
      send = (crd_cnt_reg != '0);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LINK_STOP:       if (link_en) state_next = LINK_ACTIVATE;
      LINK_ACTIVATE:   if (TXLINKACTIVEACK) state_next = LINK_RUN;
      LINK_RUN:        if (!link_en) state_next = LINK_DEACTIVATE;
      LINK_DEACTIVATE: if (!TXLINKACTIVEACK && crd_cnt_reg == '0 && !flitv_reg)
                         state_next = LINK_STOP;
      default:         state_next = LINK_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= LINK_STOP;
      crd_cnt_reg <= '0;
      crd_ovf_reg <= 1'b0;
      pend_reg    <= 1'b0;
      flitv_reg   <= 1'b0;
      proto_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= (state_next == LINK_RUN) || (state_next == LINK_DEACTIVATE);
      flitv_reg <= send;
      proto_reg <= pop;
      // A grant and a spend in the same cycle cancel out.
      if (grant && !send) begin
        if (crd_cnt_reg == 4'(MAX_CRD)) crd_ovf_reg <= 1'b1;
        else                            crd_cnt_reg <= crd_cnt_reg + 1'b1;
      end else if (send && !grant) begin
        crd_cnt_reg <= crd_cnt_reg - 1'b1;
      end
    end
  end

  always_comb begin
    lcrd_flit = '0;
    lcrd_flit[REQ_OPCODE_MSB:REQ_OPCODE_LSB] = REQ_OPC_LCRDRETURN;
  end

  assign TXLINKACTIVEREQ = (state_reg == LINK_ACTIVATE) || (state_reg == LINK_RUN);
  assign TXREQFLITPEND   = pend_reg;
  assign TXREQFLITV      = flitv_reg;
  assign TXREQFLIT       = !flitv_reg ? '0 : (proto_reg ? fifo_dout : lcrd_flit);
  assign crd_cnt         = crd_cnt_reg;
  assign crd_ovf         = crd_ovf_reg;
  assign link_state      = state_reg;

`ifdef CHI_TXREQ_PERF_EN
  logic [31:0] perf_sent_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_sent_reg  <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (pop) perf_sent_reg <= perf_sent_reg + 1'b1;
      if (state_reg == LINK_RUN && !fifo_empty && crd_cnt_reg == '0)
        perf_stall_reg <= perf_stall_reg + 1'b1;
    end
  end

  assign perf_sent  = perf_sent_reg;
  assign perf_stall = perf_stall_reg;
`else
  assign perf_sent  = '0;
  assign perf_stall = '0;
`endif

endmodule
